ib_lut_loader: RTL
==================

IB_LUT_LOADER -- requirements
Module: ib_lut_loader

Interface
REQ-001 SHALL have parameters: VN_RD_BW 8 (VN LUT word width); DN_RD_BW 2 (DN LUT word width); VN_ADDR_BW 11; DN_ADDR_BW 11; VN_WORDS 1024 (words per VN bank, 2..2^VN_ADDR_BW); DN_WORDS 1024 (DN words, 2..2^DN_ADDR_BW).
REQ-002 SHALL use one clock, write_clk; reset is rst, synchronous, active-high.
REQ-003 Ports (name  direction  width  meaning):
- write_clk  in  1  clock for all state and write strobes
- rst  in  1  synchronous active-high reset
- start  in  1  begin a load sequence; sampled in IDLE only
- abort  in  1  cancel the load in progress
- in_data  in  VN_RD_BW  LUT word stream
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a word this cycle
- vn_waddr  out  VN_ADDR_BW  VN bank write address
- vn_wdata  out  VN_RD_BW  VN bank write data
- vn_m0_we  out  1  write strobe for VN bank m0
- vn_m1_we  out  1  write strobe for VN bank m1
- dn_waddr  out  DN_ADDR_BW  DN bank write address
- dn_wdata  out  DN_RD_BW  DN bank write data
- dn_we  out  1  write strobe for DN bank
- busy  out  1  high from start acceptance until done or abort
- done  out  1  one-cycle pulse when the full sequence is written

Function
REQ-004 SHALL implement the states IDLE, LD_M0, LD_M1, LD_DN and FIN.
REQ-005 A beat SHALL be accepted when in_valid and in_ready are both high.
REQ-006 in_ready SHALL be high only in LD_M0, LD_M1 and LD_DN, and SHALL be combinational from state.
REQ-007 IDLE with start=1 SHALL go to LD_M0 on the next edge, clear the word counter, and set busy.
REQ-008 In LD_M0, LD_M1 and LD_DN, each accepted beat SHALL increment the word counter.
REQ-009 The state SHALL advance LD_M0 -> LD_M1 -> LD_DN when the counter equals VN_WORDS-1 on an accepted beat, and the counter SHALL wrap to 0 at that point.
REQ-010 In LD_DN, the beat accepted at counter DN_WORDS-1 SHALL move the state to FIN.
REQ-011 Write latency SHALL be one cycle: a beat accepted at edge t drives the registered strobe, address and data during cycle t+1; strobes are high for exactly one cycle per beat.
REQ-012 In LD_M0, an accepted beat SHALL produce vn_m0_we=1, vn_waddr=counter and vn_wdata=in_data.
REQ-013 In LD_M1, an accepted beat SHALL produce the same on vn_m1_we.
REQ-014 In LD_DN, an accepted beat SHALL produce dn_we=1, dn_waddr=counter and dn_wdata=in_data[DN_RD_BW-1:0]; the upper bits SHALL be discarded.
REQ-015 At most one write strobe SHALL be high in any cycle.
REQ-016 The counter SHALL be sized to max(VN_ADDR_BW, DN_ADDR_BW) bits, and addresses SHALL be truncated from it to their port width.
REQ-017 In FIN, done SHALL be 1 for one cycle; busy SHALL drop in the same cycle, and the state SHALL return to IDLE on the next edge.
REQ-018 A cycle with in_valid=0 SHALL stall: no strobe, counter held.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 abort=1 in any LD state SHALL take the state to IDLE on the next edge and clear the counter and busy.
REQ-021 On abort, the beat presented in the abort cycle SHALL be discarded (in_ready still high but no write) and done SHALL NOT pulse.
REQ-022 The strobe of a beat accepted one cycle before abort SHALL still occur.
REQ-023 abort in IDLE or FIN SHALL have no effect.
REQ-024 When abort and start are high together in IDLE, start SHALL win.
REQ-025 Address and data outputs SHALL hold their last value when no strobe is active.

Reset
REQ-026 When rst=1 at an edge, the state SHALL become IDLE and the counter 0.
REQ-027 After that edge, in_ready, vn_m0_we, vn_m1_we, dn_we, busy and done SHALL all be 0, and vn_waddr, vn_wdata, dn_waddr and dn_wdata SHALL all be 0.
REQ-028 rst SHALL take priority over start and abort.
REQ-029 rst mid-load SHALL suppress the strobe of a beat accepted in the preceding cycle.

Verification
REQ-030 The bench SHALL cover these scenarios, with VN_WORDS=4 and DN_WORDS=3:
- Full load: start, then 11 back-to-back beats with values 1..11 -> m0 writes addresses 0..3 with data 1..4; m1 writes 0..3 with data 5..8; DN writes 0..2 with data 9..11 masked to 2 bits (1,2,3); done pulses once, 2 cycles after beat 11.
- Stall: in_valid toggles 1,0,1,0 during LD_M0 -> exactly 2 m0 writes, at addresses 0 and 1, and no strobe in the stall cycles.
- Abort: abort asserted with beat 6 -> m1 address 0 written with data 5 and no further write; busy=0 and no done; a subsequent start restarts at m0 address 0.
- start while busy: pulse start in LD_M1 -> no counter or state change.
- Reset mid-load: rst during LD_DN, counter 1 -> all outputs 0 on the next cycle and no dn_we.
- Width: in_data=8'hFE in LD_DN -> dn_wdata=2'b10.

Source files
------------

// File: rtl/ib_lut_loader.sv
// LUT loader: turns a beat stream into writes for VN banks m0 and m1, then the DN bank.
// Each accepted beat drives a one-cycle registered write strobe with its address and data.
module ib_lut_loader #(
    parameter int VN_RD_BW   = 8,
    parameter int DN_RD_BW   = 2,
    parameter int VN_ADDR_BW = 11,
    parameter int DN_ADDR_BW = 11,
    parameter int VN_WORDS   = 1024,
    parameter int DN_WORDS   = 1024
) (
    input  logic                  write_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [VN_RD_BW-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [VN_ADDR_BW-1:0] vn_waddr,
    output logic [VN_RD_BW-1:0]   vn_wdata,
    output logic                  vn_m0_we,
    output logic                  vn_m1_we,
    output logic [DN_ADDR_BW-1:0] dn_waddr,
    output logic [DN_RD_BW-1:0]   dn_wdata,
    output logic                  dn_we,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_BW = (VN_ADDR_BW > DN_ADDR_BW) ? VN_ADDR_BW : DN_ADDR_BW;
    localparam logic [CNT_BW-1:0] VN_LAST = CNT_BW'(VN_WORDS - 1);
    localparam logic [CNT_BW-1:0] DN_LAST = CNT_BW'(DN_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_M0,
        LD_M1,
        LD_DN,
        FIN
    } state_t;

    state_t             state;
    logic [CNT_BW-1:0]  cnt;
    logic               m0_we_q;
    logic               m1_we_q;
    logic               dn_we_q;
    logic               accept;

    assign in_ready = (state == LD_M0) || (state == LD_M1) || (state == LD_DN);
    assign accept   = in_valid && in_ready;

    // A reset arriving while a strobe is pending must keep that write off the bank.
    assign vn_m0_we = m0_we_q && !rst;
    assign vn_m1_we = m1_we_q && !rst;
    assign dn_we    = dn_we_q && !rst;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below reads the pre-edge values of state and cnt.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            m0_we_q  <= 1'b0;
            m1_we_q  <= 1'b0;
            dn_we_q  <= 1'b0;
            vn_waddr <= '0;
            vn_wdata <= '0;
            dn_waddr <= '0;
            dn_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            m0_we_q <= 1'b0;
            m1_we_q <= 1'b0;
            dn_we_q <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LD_M0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LD_M0, LD_M1: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        m0_we_q  <= (state == LD_M0);
                        m1_we_q  <= (state == LD_M1);
                        vn_waddr <= cnt[VN_ADDR_BW-1:0];
                        vn_wdata <= in_data;
                        if (cnt == VN_LAST) begin
                            cnt   <= '0;
                            state <= (state == LD_M0) ? LD_M1 : LD_DN;
                        end else begin
                            cnt <= cnt + CNT_BW'(1);
                        end
                    end
                end
                LD_DN: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        dn_we_q  <= 1'b1;
                        dn_waddr <= cnt[DN_ADDR_BW-1:0];
                        dn_wdata <= in_data[DN_RD_BW-1:0];
                        if (cnt == DN_LAST) begin
                            cnt   <= '0;
                            state <= FIN;
                        end else begin
                            cnt <= cnt + CNT_BW'(1);
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
